// File: rtl/qcm_code_dispatcher_if.sv
// Code-dispatcher bus: raw codes in; settled codes, enables, change strobes and pulse trains out.
// master drives code_in (look-up stage side), slave is the dispatcher itself.
interface qcm_code_dispatcher_if #(
   parameter int NCH = 2,
   parameter int W   = 7
);
   logic [NCH*W-1:0] code_in;
   logic [NCH*W-1:0] code_out;
   logic [NCH-1:0]   enable;
   logic [NCH-1:0]   code_changed;
   logic [NCH-1:0]   ser_out;
   logic [NCH-1:0]   busy;

   modport master (output code_in, input code_out, enable, code_changed, ser_out, busy);
   modport slave  (input code_in, output code_out, enable, code_changed, ser_out, busy);
endinterface

// File: rtl/qcm_code_dispatcher.sv
// Per-channel settle filter (latch SETTLE edges after a code first appears) feeding a framed serial encoder.
// Encoder steps once per 2^DIV_LOG2-clk tick; no backpressure, frames are sent from a shadow copy.
module qcm_code_dispatcher #(
   parameter int NCH      = 2,
   parameter int W        = 7,
   parameter int SETTLE   = 16,
   parameter int DIV_LOG2 = 4,
   parameter int GAP      = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   qcm_code_dispatcher_if.slave bus
);
   localparam int CW   = $clog2(SETTLE);
   localparam int PMAX = (W > GAP) ? W : GAP;
   localparam int PW   = $clog2(PMAX);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DELIM, S_DATA, S_PAR, S_STOP} enc_state_e;

   logic [NCH-1:0][W-1:0]  code_in_w;
   logic [NCH-1:0][W-1:0]  cand_q, cand_d, code_q, code_d;
   logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]         en_q, en_d, chg_q, chg_d;

   logic [DIV_LOG2-1:0]    div_q;
   logic                   tick;

   enc_state_e             state_q [NCH];
   enc_state_e             state_d [NCH];
   logic [PW-1:0]          phase_q [NCH];
   logic [PW-1:0]          phase_d [NCH];
   logic [W-1:0]           shadow_q [NCH];
   logic [W-1:0]           shadow_d [NCH];
   logic [NCH-1:0]         ser_q, ser_d, busy_q, busy_d;

   assign code_in_w = bus.code_in;
   assign tick      = &div_q;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      code_d = code_q;
      en_d   = en_q;
      chg_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (code_in_w[i] != cand_q[i]) begin
            cand_d[i] = code_in_w[i];
            cnt_d[i]  = '0;
            en_d[i]   = 1'b0;
         end else if (cnt_q[i] != CW'(SETTLE - 1)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else begin
            // cnt saturates here; the strobe fires once because code_q catches up with cand
            code_d[i] = cand_q[i];
            en_d[i]   = 1'b1;
            chg_d[i]  = (cand_q[i] != code_q[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q <= '0;
         cnt_q  <= '0;
         code_q <= '0;
         en_q   <= '0;
         chg_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         code_q <= code_d;
         en_q   <= en_d;
         chg_q  <= chg_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         ser_q  <= '0;
         busy_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            state_q[i]  <= S_IDLE;
            phase_q[i]  <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         div_q  <= div_q + 1'b1;
         ser_q  <= ser_d;
         busy_q <= busy_d;
         for (int i = 0; i < NCH; i++) begin
            state_q[i]  <= state_d[i];
            phase_q[i]  <= phase_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i]  = state_q[i];
         phase_d[i]  = phase_q[i];
         shadow_d[i] = shadow_q[i];
         if (tick) begin
            case (state_q[i])
               S_IDLE: if (en_q[i]) begin
                  state_d[i]  = S_START;
                  phase_d[i]  = '0;
                  shadow_d[i] = code_q[i];
               end
               S_START: if (phase_q[i] == PW'(1)) begin
                  state_d[i] = S_DELIM;
                  phase_d[i] = '0;
               end else begin
                  phase_d[i] = phase_q[i] + 1'b1;
               end
               S_DELIM: begin
                  state_d[i] = S_DATA;
                  phase_d[i] = '0;
               end
               S_DATA: if (phase_q[i] == PW'(W - 1)) begin
                  state_d[i] = S_PAR;
                  phase_d[i] = '0;
               end else begin
                  phase_d[i] = phase_q[i] + 1'b1;
               end
               S_PAR: begin
                  state_d[i] = S_STOP;
                  phase_d[i] = '0;
               end
               S_STOP: if (phase_q[i] == PW'(GAP - 1)) begin
                  // the IDLE decision is folded into the last gap tick so frames abut
                  phase_d[i] = '0;
                  if (en_q[i]) begin
                     state_d[i]  = S_START;
                     shadow_d[i] = code_q[i];
                  end else begin
                     state_d[i] = S_IDLE;
                  end
               end else begin
                  phase_d[i] = phase_q[i] + 1'b1;
               end
               default: begin
                  state_d[i] = S_IDLE;
                  phase_d[i] = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      logic [W-1:0] sh;
      sh     = '0;
      ser_d  = '0;
      busy_d = '0;
      for (int i = 0; i < NCH; i++) begin
         sh = shadow_d[i] << phase_d[i];
         case (state_d[i])
            S_START: ser_d[i] = 1'b1;
            S_DATA:  ser_d[i] = sh[W-1];
            S_PAR:   ser_d[i] = ^shadow_d[i];
            default: ser_d[i] = 1'b0;
         endcase
         busy_d[i] = (state_d[i] != S_IDLE);
      end
   end

   assign bus.code_out     = code_q;
   assign bus.enable       = en_q;
   assign bus.code_changed = chg_q;
   assign bus.ser_out      = ser_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_qcm_code_dispatcher.sv
// Randomised bench for qcm_code_dispatcher against a sliding-window / frame-queue reference model.
// Directed openings (reset, 0x55, glitched 0x07, mid-DATA change, mid-frame reset) then random codes.
module tb_qcm_code_dispatcher;
   localparam int NCH = 2, W = 7, SETTLE = 4, DIV_LOG2 = 2, GAP = 3;
   localparam int FLEN = W + 4 + GAP;
   localparam int TPER = 1 << DIV_LOG2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   qcm_code_dispatcher_if #(.NCH(NCH), .W(W)) bus();

   qcm_code_dispatcher #(
      .NCH(NCH), .W(W), .SETTLE(SETTLE), .DIV_LOG2(DIV_LOG2), .GAP(GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] code_v [NCH];
   logic [W-1:0] base   [NCH];

   // reference model: a code is settled when the last SETTLE+1 sampled values agree
   int           edge_n;
   int           hcnt;
   logic [W-1:0] hist     [NCH][SETTLE+1];
   logic [W-1:0] m_code   [NCH];
   logic         m_en     [NCH];
   logic         m_chg    [NCH];
   logic         m_ser    [NCH];
   logic         m_busy   [NCH];
   logic         fbits    [NCH][FLEN];
   int           flen     [NCH];
   int           fpos     [NCH];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      logic [NCH*W-1:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i*W +: W] = code_v[i];
      bus.code_in = v;
   endtask

   task automatic model_reset();
      edge_n = 0;
      hcnt   = 1;
      for (int i = 0; i < NCH; i++) begin
         for (int k = 0; k <= SETTLE; k++) hist[i][k] = '0;
         m_code[i] = '0;
         m_en[i]   = 1'b0;
         m_chg[i]  = 1'b0;
         m_ser[i]  = 1'b0;
         m_busy[i] = 1'b0;
         flen[i]   = 0;
         fpos[i]   = 0;
      end
   endtask

   task automatic model_edge();
      logic tick;
      logic win;
      edge_n++;
      tick = (edge_n >= TPER) && (edge_n % TPER == 0);
      hcnt = (hcnt < SETTLE + 1) ? hcnt + 1 : hcnt;
      for (int i = 0; i < NCH; i++) begin
         if (tick) begin
            if (fpos[i] >= flen[i] && m_en[i]) begin
               for (int b = 0; b < FLEN; b++) fbits[i][b] = 1'b0;
               fbits[i][0] = 1'b1;
               fbits[i][1] = 1'b1;
               for (int b = 0; b < W; b++) fbits[i][3+b] = m_code[i][W-1-b];
               fbits[i][3+W] = ^m_code[i];
               flen[i] = FLEN;
               fpos[i] = 0;
            end
            if (fpos[i] < flen[i]) begin
               m_ser[i]  = fbits[i][fpos[i]];
               m_busy[i] = 1'b1;
               fpos[i]++;
            end else begin
               m_ser[i]  = 1'b0;
               m_busy[i] = 1'b0;
               flen[i]   = 0;
               fpos[i]   = 0;
            end
         end
         for (int k = 0; k < SETTLE; k++) hist[i][k] = hist[i][k+1];
         hist[i][SETTLE] = code_v[i];
         win = (hcnt == SETTLE + 1);
         for (int k = 0; k < SETTLE; k++) if (hist[i][k] != hist[i][SETTLE]) win = 1'b0;
         m_chg[i] = win && !m_en[i] && (hist[i][SETTLE] != m_code[i]);
         if (win) m_code[i] = hist[i][SETTLE];
         m_en[i] = win;
      end
   endtask

   task automatic compare_all();
      logic [NCH*W-1:0] e_code;
      logic [NCH-1:0]   e_en, e_chg, e_ser, e_busy;
      e_code = '0;
      e_en = '0; e_chg = '0; e_ser = '0; e_busy = '0;
      for (int i = 0; i < NCH; i++) begin
         e_code[i*W +: W] = m_code[i];
         e_en[i]   = m_en[i];
         e_chg[i]  = m_chg[i];
         e_ser[i]  = m_ser[i];
         e_busy[i] = m_busy[i];
      end
      check_eq("code_out", bus.code_out, e_code);
      check_eq("enable", bus.enable, e_en);
      check_eq("code_changed", bus.code_changed, e_chg);
      check_eq("ser_out", bus.ser_out, e_ser);
      check_eq("busy", bus.busy, e_busy);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      logic found;
      int   r;

      for (int i = 0; i < NCH; i++) code_v[i] = '0;
      drive();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      #1 rst_n = 1'b1;

      // codes held at zero after reset: enable at edge 4, zero frames
      repeat (80) step();

      // ch0 0x55, ch1 0x07 with a one-cycle 0x08 glitch on its third sample
      code_v[0] = 7'h55;
      code_v[1] = 7'h07;
      drive();
      step();
      step();
      code_v[1] = 7'h08;
      drive();
      step();
      code_v[1] = 7'h07;
      drive();
      repeat (150) step();

      // change ch0 while its encoder is in DATA
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         if (flen[0] != 0 && fpos[0] >= 5 && fpos[0] <= 8) found = 1'b1;
      end
      check_eq("wait_data", found, 1'b1);
      code_v[0] = 7'h2A;
      drive();
      repeat (150) step();

      // random codes with occasional single-cycle glitches
      for (int i = 0; i < NCH; i++) base[i] = code_v[i];
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NCH; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2) base[i] = W'($urandom);
            code_v[i] = (r == 2) ? W'($urandom) : base[i];
         end
         drive();
         step();
      end

      // reset in the middle of frames on both channels
      for (int i = 0; i < NCH; i++) code_v[i] = W'($urandom);
      drive();
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         step();
         if (m_busy[0] && m_busy[1] && fpos[0] > 2 && fpos[1] > 2) found = 1'b1;
      end
      check_eq("wait_busy", found, 1'b1);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (200) step();

      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NCH; i++) begin
            r = $urandom_range(0, 149);
            if (r < 2) base[i] = W'($urandom);
            code_v[i] = (r == 2) ? W'($urandom) : base[i];
         end
         drive();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/qcm_code_dispatcher.md
# qcm_code_dispatcher

Parametrised multi-channel code dispatcher for the QCM master controller. It takes NCH capacitor-state codes from the look-up stage, qualifies each one with a settle filter, and presents the latched code with an enable to the decoder boards. It also emits a framed, parity-protected pulse train per channel on a divided tick, readable by the 2.5 MHz digitizer. It generalises the per-channel driver and pulse-encoder pair to any channel count and code width, and adds change strobes, start/parity framing and glitch-free code capture.

## Interface
- NCH, 2: number of independent code channels (≥1).
- W, 7: code width in bits (2..16).
- SETTLE, 16: consecutive clk cycles a code must be stable before it is latched (≥2).
- DIV_LOG2, 4: encoder tick period is 2^DIV_LOG2 clk cycles (≥1).
- GAP, 3: idle low ticks after each frame (≥3).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- code_in  in  NCH*W  raw codes; channel i occupies bits [i*W+W-1 : i*W].
- code_out  out  NCH*W  settled, latched codes; same packing.
- enable  out  NCH  channel code settled and valid.
- code_changed  out  NCH  one-cycle strobe when code_out[i] takes a value different from its previous value.
- ser_out  out  NCH  framed pulse train per channel.
- busy  out  NCH  channel encoder is mid-frame (any state other than IDLE).

## Operation
- Reset (asynchronous, rst_n low): all outputs 0; candidate, counter, shadow and divider registers 0; every encoder in IDLE.
- Settle filter, per channel, evaluated every clk:
  - If code_in[i] ≠ cand[i]: cand ← code_in[i], cnt ← 0, enable[i] ← 0.
  - Else if cnt < SETTLE-1: cnt ← cnt+1.
  - Else: code_out[i] ← cand[i], enable[i] ← 1, cnt saturates. code_changed[i] ← 1 only when cand ≠ the old code_out[i], and only on the first latching cycle.
  - code_out[i] holds its last settled value while enable[i] is low.
- Divider: a DIV_LOG2-bit free-running counter. tick is a one-clk strobe when the counter is all ones. All encoders share it.
- Encoder FSM per channel, advances only on tick:
  - IDLE: ser=0. If enable[i]=1: shadow ← code_out[i], go to START, phase ← 0.
  - START: ser=1 for 2 ticks, then DELIM.
  - DELIM: ser=0 for 1 tick, then DATA.
  - DATA: ser=shadow bit, MSB first, W ticks, then PAR.
  - PAR: ser=even parity (XOR of shadow bits) for 1 tick, then STOP.
  - STOP: ser=0 for GAP ticks, then IDLE. The IDLE check happens at the same tick, so frames run back to back while enable stays high.
- Frame length is W+4+GAP ticks.
- Changes to code_out or enable mid-frame never alter the frame in progress, because it is sent from shadow.
- If enable falls, the current frame still completes. No new frame starts while enable is low.
- Channels are independent. Simultaneous changes on several channels are handled in parallel with no interaction.

## Timing
- New code first sampled at edge E0 (cand updates at E0). If code_in stays constant, code_out, enable and code_changed update at edge E0+SETTLE.
- Any code_in change clears enable on the very next edge, with 1-cycle latency.
- A single-cycle glitch resets cnt. The code then re-settles SETTLE cycles after the glitch clears, and code_out is unchanged if the glitch returns to the latched value. In that case code_changed stays 0 and enable re-asserts.
- First tick occurs 2^DIV_LOG2 edges after rst_n deassertion (divider reaches all ones at edge 2^DIV_LOG2-1, strobe sampled at the next edge).
- ser_out and busy are registered and change only on edges where tick is sampled high. busy rises with the START entry.
- Reset asserted mid-frame forces ser_out=0 and IDLE immediately (asynchronous). No partial frame resumes.

## Test plan
- Test configuration: NCH=2, W=7, SETTLE=4, DIV_LOG2=2, GAP=3.
- Reset release, code_in held at 0: enable=0b11 at cycle 4; code_changed stays 0 (0 equals the reset value); ser_out starts frames of 1,1,0,0000000,0,000.
- Channel 0 code_in=7'h55 stable: enable[0] drops next edge, then re-asserts with code_changed[0] pulse exactly 4 edges after first sample. ser_out[0] sequence per 4-clk tick: 1,1,0,1,0,1,0,1,0,1,0,0,0,0 (14 ticks, 56 clk), repeating.
- Channel 1 code_in=7'h07 with a one-cycle glitch to 7'h08 at cycle 2 of settling: latch occurs 4 edges after the glitch clears, never at 7'h08. The frame carries parity 1: ...,0,0,0,0,1,1,1,1,0,0,0.
- code_in[0] changes from 7'h55 to 7'h2A during the DATA state: the current frame finishes with 7'h55 bits. The next frame carries 7'h2A only if enable is high at the frame's IDLE tick.
- rst_n pulsed low mid-frame on both channels: ser_out, busy, enable, code_out read 0 within the same cycle. The divider restarts, and the first tick after release is at edge 4.
